// File: rtl/pll_cfg_pkg.sv
// pll_cfg_pkg: FSM states and default ADF-style register set for the PLL serial programmer
package pll_cfg_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_SEL, S_LOAD, S_SHIFT, S_LATCH, S_GAP, S_WAIT, S_DONE, S_ERR
  } pll_state_e;
  localparam logic [31:0] PLL_DEF_REG0 = 32'h0050_0000;
  localparam logic [31:0] PLL_DEF_REG1 = 32'h0800_8011;
  localparam logic [31:0] PLL_DEF_REG2 = 32'h0000_4E42;
  localparam logic [31:0] PLL_DEF_REG3 = 32'h0000_04B3;
  localparam logic [31:0] PLL_DEF_REG4 = 32'h009C_803C;
  localparam logic [31:0] PLL_DEF_REG5 = 32'h0058_0005;
  localparam logic [191:0] PLL_DEF_WORDS = {PLL_DEF_REG5, PLL_DEF_REG4, PLL_DEF_REG3,
                                            PLL_DEF_REG2, PLL_DEF_REG1, PLL_DEF_REG0};
endpackage

// File: rtl/pll_sclk_gen.sv
// pll_sclk_gen: serial clock divider with rise/fall strobes, held low while disabled
module pll_sclk_gen #(
  parameter int CLK_DIV = 5
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] cnt;
  logic tc;
  assign tc   = en && cnt == DW'(CLK_DIV - 1);
  assign rise = tc && !sclk;
  assign fall = tc && sclk;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      cnt  <= (!en || tc) ? '0 : cnt + 1'b1;
      sclk <= en && (sclk ^ tc);
    end
  end
endmodule

// File: rtl/pll_serial_programmer.sv
// pll_serial_programmer: 3-wire PLL register loader with lock-detect wait and timeout
module pll_serial_programmer
  import pll_cfg_pkg::*;
#(
  parameter int NUM_REGS     = 6,
  parameter int REG_WIDTH    = 32,
  parameter int CLK_DIV      = 5,
  parameter int LE_HOLD      = 1,
  parameter int LOCK_TIMEOUT = 65535,
  parameter bit AUTO_START   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start,
  input  logic [NUM_REGS*REG_WIDTH-1:0] reg_words,
  input  logic [NUM_REGS-1:0]           reg_mask,
  input  logic                          pll_ld,
  output logic                          pll_ce,
  output logic                          pll_clk,
  output logic                          pll_dat,
  output logic                          pll_le,
  output logic                          busy,
  output logic                          done,
  output logic                          lock_err
);
  localparam int IW     = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam int BW     = $clog2(REG_WIDTH);
  localparam int LE_CYC = 2 * CLK_DIV * LE_HOLD;
  localparam int GAP_CYC = 2 * CLK_DIV;
  localparam int CMAX   = LE_CYC > LOCK_TIMEOUT ? LE_CYC : LOCK_TIMEOUT;
  localparam int CW     = $clog2(CMAX + 1);
  pll_state_e                    state;
  logic [NUM_REGS*REG_WIDTH-1:0] words;
  logic [NUM_REGS-1:0]           mask;
  logic [IW-1:0]                 idx;
  logic [REG_WIDTH-1:0]          sh;
  logic [BW-1:0]                 bitcnt;
  logic [CW-1:0]                 cnt;
  logic [2:0]                    ld_s;
  logic                          auto_pend, tail, rise, fall, lock_ok;
  assign pll_ce  = 1'b1;
  assign lock_ok = ld_s[2] & ld_s[1];
  pll_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk (clk),
    .rstn(rstn),
    .en  (state == S_SHIFT),
    .sclk(pll_clk),
    .rise(rise),
    .fall(fall)
  );
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      words     <= '0;
      mask      <= '0;
      idx       <= '0;
      sh        <= '0;
      bitcnt    <= '0;
      cnt       <= '0;
      ld_s      <= '0;
      auto_pend <= AUTO_START;
      tail      <= 1'b0;
      pll_dat   <= 1'b0;
      pll_le    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      lock_err  <= 1'b0;
    end else begin
      auto_pend <= 1'b0;
      ld_s      <= {ld_s[1:0], pll_ld};
      case (state)
        S_IDLE: if (start || auto_pend) begin
          words    <= reg_words;
          mask     <= reg_mask;
          idx      <= IW'(NUM_REGS - 1);
          done     <= 1'b0;
          lock_err <= 1'b0;
          busy     <= 1'b1;
          state    <= S_SEL;
        end
        S_SEL: if (mask[idx]) state <= S_LOAD;
          else if (idx == '0) begin
            cnt   <= '0;
            state <= S_WAIT;
          end else idx <= idx - 1'b1;
        // the selected mask bit is cleared so SEL resumes the scan from the same index
        S_LOAD: begin
          sh        <= words[idx*REG_WIDTH +: REG_WIDTH] << 1;
          pll_dat   <= words[idx*REG_WIDTH + REG_WIDTH - 1];
          mask[idx] <= 1'b0;
          bitcnt    <= BW'(REG_WIDTH - 1);
          tail      <= 1'b0;
          state     <= S_SHIFT;
        end
        // tail marks that bit 0 has been sampled; its falling edge ends the frame
        S_SHIFT: begin
          if (rise && bitcnt == '0) tail <= 1'b1;
          if (fall && tail) begin
            pll_dat <= 1'b0;
            pll_le  <= 1'b1;
            cnt     <= '0;
            state   <= S_LATCH;
          end else if (fall) begin
            bitcnt  <= bitcnt - 1'b1;
            pll_dat <= sh[REG_WIDTH-1];
            sh      <= sh << 1;
          end
        end
        S_LATCH: if (cnt == CW'(LE_CYC - 1)) begin
          pll_le <= 1'b0;
          cnt    <= '0;
          state  <= S_GAP;
        end else cnt <= cnt + 1'b1;
        S_GAP: if (cnt == CW'(GAP_CYC - 1)) state <= S_SEL;
          else cnt <= cnt + 1'b1;
        S_WAIT: if (LOCK_TIMEOUT == 0 || lock_ok) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_DONE;
        end else if (cnt == CW'(LOCK_TIMEOUT)) begin
          lock_err <= 1'b1;
          busy     <= 1'b0;
          state    <= S_ERR;
        end else cnt <= cnt + 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pll_serial_programmer.sv
// tb_pll_serial_programmer: random-word frame checker against a word-level model of the load sequence
module tb_pll_serial_programmer;
  import pll_cfg_pkg::*;
  localparam int N = 6;
  localparam int W = 32;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, pll_ld = 1'b0;
  logic [N*W-1:0] reg_words;
  logic [N-1:0] reg_mask;
  logic pll_ce, pll_clk, pll_dat, pll_le, busy, done, lock_err;
  logic start0 = 1'b0, ld0 = 1'b0;
  logic [15:0] words0 = 16'hA5C3;
  logic [1:0] mask0 = 2'b00;
  logic ce0, clk0, dat0, le0, busy0, done0, err0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pll_serial_programmer #(.LOCK_TIMEOUT(100)) dut (
    .clk(clk), .rstn(rstn), .start(start), .reg_words(reg_words), .reg_mask(reg_mask),
    .pll_ld(pll_ld), .pll_ce(pll_ce), .pll_clk(pll_clk), .pll_dat(pll_dat), .pll_le(pll_le),
    .busy(busy), .done(done), .lock_err(lock_err)
  );
  pll_serial_programmer #(.NUM_REGS(2), .REG_WIDTH(8), .CLK_DIV(2), .LOCK_TIMEOUT(0),
                          .AUTO_START(1'b0)) dut0 (
    .clk(clk), .rstn(rstn), .start(start0), .reg_words(words0), .reg_mask(mask0),
    .pll_ld(ld0), .pll_ce(ce0), .pll_clk(clk0), .pll_dat(dat0), .pll_le(le0),
    .busy(busy0), .done(done0), .lock_err(err0)
  );
  logic [W-1:0] acc = '0;
  logic [W-1:0] fr[64];
  int fbits[64], lew[64];
  int nb = 0, last_nb = 0, nfr = 0, nrise = 0, lecnt = 0, nle = 0, nrise0 = 0;
  always @(posedge pll_clk or negedge rstn)
    if (!rstn) nb = 0;
    else begin
      acc = {acc[W-2:0], pll_dat};
      nb++;
      nrise++;
    end
  always @(posedge pll_le or negedge rstn)
    if (!rstn) last_nb = 0;
    else begin
      if (nfr < 64) begin
        fr[nfr] = acc;
        fbits[nfr] = nb - last_nb;
      end
      nfr++;
      last_nb = nb;
    end
  always @(negedge clk)
    if (pll_le) lecnt++;
    else if (lecnt != 0) begin
      if (nle < 64) lew[nle] = lecnt;
      nle++;
      lecnt = 0;
    end
  always @(posedge clk0) nrise0++;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask
  task automatic rand_words();
    for (int i = 0; i < N; i++) reg_words[i*W +: W] = $urandom();
  endtask
  task automatic wait_end(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (!busy && (done || lock_err)) break;
      @(negedge clk);
    end
    check({tag, "_in_time"}, i < budget, 1);
  endtask
  task automatic expect_frames(input string tag, input logic [N*W-1:0] w, input logic [N-1:0] m,
                               input int fb, input int rb);
    int k = fb;
    for (int i = N - 1; i >= 0; i--)
      if (m[i] && k < 64) begin
        check({tag, "_word"}, fr[k], w[i*W +: W]);
        check({tag, "_bits"}, fbits[k], W);
        check({tag, "_le_w"}, lew[k], 10);
        k++;
      end
    check({tag, "_nframes"}, nfr - fb, $countones(m));
    check({tag, "_rises"}, nrise - rb, $countones(m) * W);
  endtask
  initial begin
    logic [N*W-1:0] snap;
    logic [N-1:0] m;
    int fb, rb, c;
    reg_words = PLL_DEF_WORDS;
    reg_mask  = 6'h3F;
    pll_ld    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ce", pll_ce, 1);
    check("rst_clk", pll_clk, 0);
    check("rst_dat", pll_dat, 0);
    check("rst_le", pll_le, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", lock_err, 0);
    snap = reg_words; fb = nfr; rb = nrise;
    rstn = 1'b1;
    @(negedge clk);
    wait_end("t1", 4000);
    check("t1_done", done, 1);
    check("t1_first", fr[0], 32'h0058_0005);
    expect_frames("t1", snap, 6'h3F, fb, rb);
    rand_words();
    reg_mask = 6'b000101;
    snap = reg_words; fb = nfr; rb = nrise;
    pulse_start();
    wait_end("t2", 4000);
    check("t2_done", done, 1);
    expect_frames("t2", snap, 6'b000101, fb, rb);
    for (int r = 0; r < 4; r++) begin
      rand_words();
      m = 6'($urandom_range(63, 1));
      reg_mask = m;
      snap = reg_words; fb = nfr; rb = nrise;
      pulse_start();
      wait_end("rnd", 4000);
      check("rnd_done", done, 1);
      expect_frames("rnd", snap, m, fb, rb);
    end
    rand_words();
    reg_mask = 6'h3F;
    snap = reg_words; fb = nfr; rb = nrise;
    pulse_start();
    for (c = 0; c < 2000 && nfr - fb < 2; c++) @(negedge clk);
    check("t4_reach", nfr - fb, 2);
    repeat (150) @(negedge clk);
    start = 1'b1;
    rand_words();
    reg_mask = 6'($urandom());
    @(negedge clk) start = 1'b0;
    wait_end("t4", 4000);
    check("t4_done", done, 1);
    expect_frames("t4", snap, 6'h3F, fb, rb);
    pll_ld = 1'b0;
    reg_mask = 6'h00;
    repeat (4) @(negedge clk);
    pulse_start();
    for (c = 0; c < 300; c++) begin
      if (lock_err) break;
      @(negedge clk);
    end
    check("t3_err", lock_err, 1);
    check("t3_done", done, 0);
    check("t3_busy", busy, 0);
    check("t3_latency", c >= 99 && c <= 110, 1);
    pll_ld = 1'b1;
    pulse_start();
    check("t3_clr", lock_err, 0);
    check("t3_busy2", busy, 1);
    wait_end("t3b", 100);
    check("t3b_done", done, 1);
    rand_words();
    reg_mask = 6'h3F;
    pulse_start();
    repeat (100) @(negedge clk);
    fb = nfr;
    c = nle;
    #2 rstn = 1'b0;
    #1;
    check("t5_clk", pll_clk, 0);
    check("t5_dat", pll_dat, 0);
    check("t5_le", pll_le, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_err", lock_err, 0);
    repeat (3) @(negedge clk);
    check("t5_no_le", nfr - fb, 0);
    check("t5_no_lew", nle - c, 0);
    rand_words();
    snap = reg_words; fb = nfr; rb = nrise;
    rstn = 1'b1;
    @(negedge clk);
    wait_end("t5", 4000);
    check("t5_done2", done, 1);
    expect_frames("t5", snap, 6'h3F, fb, rb);
    rb = nrise0;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    for (c = 1; c < 8; c++) begin
      if (done0) break;
      @(negedge clk);
    end
    check("t6_done", done0, 1);
    check("t6_quick", c <= 4, 1);
    check("t6_rises", nrise0 - rb, 0);
    check("t6_busy", busy0, 0);
    check("t6_err", err0, 0);
    check("t6_le", le0, 0);
    check("t6_dat", dat0, 0);
    check("t6_ce", ce0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
